// File: rtl/uart_trx.sv
// Full-duplex UART: valid/ready transmitter, synchronized mid-bit receiver, FWFT RX FIFO.
// Optional macro UART_LOOPBACK_EN adds a loopback input that feeds TX back into RX internally.
module uart_trx #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
`ifdef UART_LOOPBACK_EN
  input  logic                          loopback,
`endif
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          rx_overrun
);

  localparam int CW = $clog2(STOP_BITS * CLK_DIV + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] C_STOP_END = CW'(STOP_BITS * CLK_DIV - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   C_FULL     = (AW + 1)'(FIFO_DEPTH);
  localparam bit            HAS_PAR    = (PARITY != 0);
  localparam logic          ODD        = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                 r_tx_state;
  logic [CW-1:0]          r_tx_cnt;
  logic [BW-1:0]          r_tx_bit;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic                   r_tx_par;
  logic                   r_tx;
  logic                   r_tx_ready;
  logic                   w_tx_accept;

  assign w_tx_accept = tx_valid && r_tx_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (w_tx_accept) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= (^tx_data) ^ ODD;
            r_tx       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (r_tx_cnt == C_BIT_END) begin
            r_tx_cnt   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == C_BIT_END) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == C_LAST_BIT) begin
              if (HAS_PAR) begin
                r_tx       <= r_tx_par;
                r_tx_state <= S_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_tx_state <= S_STOP;
              end
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= r_tx_bit + 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_tx_cnt == C_BIT_END) begin
            r_tx_cnt   <= '0;
            r_tx       <= 1'b1;
            r_tx_state <= S_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Stop time covers all stop bits in one count
          if (r_tx_cnt == C_STOP_END) begin
            r_tx_cnt   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                   w_rx_in;
  logic                   r_rx_s1;
  logic                   r_rx_s2;
  state_t                 r_rx_state;
  logic [CW-1:0]          r_rx_cnt;
  logic [BW-1:0]          r_rx_bit;
  logic [DATA_BITS-1:0]   r_rx_shift;
  logic                   r_rx_par_bit;
  logic                   r_rx_armed;
  logic                   r_push;
  logic [DATA_BITS-1:0]   r_push_data;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   w_par_bad;

`ifdef UART_LOOPBACK_EN
  assign w_rx_in = loopback ? r_tx : uart_rx;
  assign uart_tx = r_tx | loopback;
`else
  assign w_rx_in = uart_rx;
  assign uart_tx = r_tx;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= w_rx_in;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_par_bad = HAS_PAR && (((^r_rx_shift) ^ r_rx_par_bit) != ODD);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bit <= 1'b0;
      r_rx_armed   <= 1'b1;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_push       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          // After a framing error the line must return high before a new start is honoured
          if (!r_rx_armed) begin
            r_rx_armed <= r_rx_s2;
          end else if (!r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == C_HALF_END) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == C_BIT_END) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == C_LAST_BIT) begin
              r_rx_state <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_rx_cnt == C_BIT_END) begin
            r_rx_cnt     <= '0;
            r_rx_par_bit <= r_rx_s2;
            r_rx_state   <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == C_BIT_END) begin
            r_rx_cnt   <= '0;
            r_rx_state <= S_IDLE;
            if (!r_rx_s2) begin
              r_frame_err <= 1'b1;
              r_rx_armed  <= 1'b0;
            end else if (w_par_bad) begin
              r_parity_err <= 1'b1;
            end else begin
              r_push      <= 1'b1;
              r_push_data <= r_rx_shift;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO (first-word-fall-through) ----------------
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overrun;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_push;

  assign w_pop  = (r_count != '0) && rx_ready;
  assign w_full = (r_count == C_FULL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push = r_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (resetn && w_push) begin
      r_mem[r_wr_ptr] <= r_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_push && w_full && !w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign tx_ready   = r_tx_ready;
  assign rx_data    = r_mem[r_rd_ptr];
  assign rx_valid   = (r_count != '0);
  assign rx_count   = r_count;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_trx.sv
// Scoreboard bench for uart_trx: CLK_DIV=8, 8 data bits, even parity, 1 stop bit, 4-entry FIFO.
module tb_uart_trx;
  localparam int CLK_DIV    = 8;
  localparam int DATA_BITS  = 8;
  localparam int PARITY     = 2;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_CYC  = 11 * CLK_DIV;
  localparam int EV_FRM = 1, EV_PAR = 2, EV_OVR = 3;

  logic                 clk;
  logic                 resetn;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 uart_tx;
  logic                 uart_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [CNT_W-1:0]     rx_count;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_overrun;
`ifdef UART_LOOPBACK_EN
  logic                 loopback;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  rx_q[$];
  logic [10:0] tx_q[$];
  int          ev_q[$];

  uart_trx #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY(PARITY),
    .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
`ifdef UART_LOOPBACK_EN
    .loopback(loopback),
`endif
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_count(rx_count),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .rx_overrun(rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void ev_check(input int code, input string name);
    int e;
    check(ev_q.size() != 0, {name, "_unexpected"}, 1, 0);
    if (ev_q.size() != 0) begin
      e = ev_q.pop_front();
      check(e == code, name, code, e);
      $display("[TB] event %s at %0t", name, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame on uart_rx; with pop_at_push, rx_ready is raised for exactly the push cycle.
  task automatic send_rx(input logic [7:0] d, input logic p, input logic stop, input bit pop_at_push);
    fork
      begin
        uart_rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
          uart_rx = d[i];
          tick(CLK_DIV);
        end
        uart_rx = p;
        tick(CLK_DIV);
        uart_rx = stop;
        tick(CLK_DIV);
        uart_rx = 1'b1;
        tick(CLK_DIV);
      end
      begin
        if (pop_at_push) begin
          tick(FRAME_CYC - 1);
          rx_ready = 1'b1;
          tick(1);
          rx_ready = 1'b0;
        end
      end
    join
  endtask

  // FIFO consumer side
  always @(negedge clk) begin
    if (resetn === 1'b1 && rx_valid && rx_ready) begin
      check(rx_q.size() != 0, "rx_unexpected_pop", int'(rx_data), 0);
      if (rx_q.size() != 0) begin
        logic [7:0] e;
        e = rx_q.pop_front();
        check(rx_data == e, "rx_data", int'(rx_data), int'(e));
        $display("[TB] rx pop 0x%02h expected 0x%02h", rx_data, e);
      end
    end
  end

  // Error pulse monitor
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (frame_err)  ev_check(EV_FRM, "frame_err");
      if (parity_err) ev_check(EV_PAR, "parity_err");
      if (rx_overrun) ev_check(EV_OVR, "rx_overrun");
    end
  end

  // Serial line monitor: every cycle of a frame must match the expected bit
  initial begin : tx_mon
    logic [10:0] e;
    int bad;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && uart_tx === 1'b0) begin
        bad = 0;
        e = 11'h7FF;
        check(tx_q.size() != 0, "tx_unexpected_frame", 1, 0);
        if (tx_q.size() != 0) e = tx_q.pop_front();
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k != 0) @(negedge clk);
          if (uart_tx !== e[k / CLK_DIV]) bad++;
        end
        check(bad == 0, "tx_frame_cycles_wrong", bad, 0);
        $display("[TB] tx frame 0x%03h observed, %0d bad cycles", e, bad);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int bad;
    int n;
    resetn   = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
`ifdef UART_LOOPBACK_EN
    loopback = 1'b0;
`endif
    tick(3);
    check(uart_tx == 1'b1, "rst_uart_tx", int'(uart_tx), 1);
    check(tx_ready == 1'b1, "rst_tx_ready", int'(tx_ready), 1);
    check(rx_valid == 1'b0, "rst_rx_valid", int'(rx_valid), 0);
    check(int'(rx_count) == 0, "rst_rx_count", int'(rx_count), 0);
    check({frame_err, parity_err, rx_overrun} == 3'b000, "rst_err_pulses",
          int'({frame_err, parity_err, rx_overrun}), 0);
    $display("[TB] reset checked");
    resetn = 1'b1;
    tick(2);

    // TX 0xA5 then 0x3C back-to-back; frames {stop, parity, data, start}
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tx_q.push_back(11'h54A);
    tick(1);
    tx_data = 8'h3C;
    tx_q.push_back(11'h478);
    bad = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (tx_ready !== 1'b0) bad++;
      tick(1);
    end
    check(bad == 0, "tx_ready_low_88", bad, 0);
    check(tx_ready == 1'b1, "tx_ready_after_frame", int'(tx_ready), 1);
    tick(1);
    check(uart_tx == 1'b0, "tx_no_gap_start", int'(uart_tx), 0);
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    tick(FRAME_CYC + 4);
    $display("[TB] tx back-to-back done");

    // RX good frame, even parity bit 0
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b0, 1'b1, 1'b0);
    check(rx_valid == 1'b1, "rx_valid_3c", int'(rx_valid), 1);
    check(int'(rx_count) == 1, "rx_count_3c", int'(rx_count), 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check(int'(rx_count) == 0, "rx_count_after_pop", int'(rx_count), 0);

    // Parity mismatch
    ev_q.push_back(EV_PAR);
    send_rx(8'h3C, 1'b1, 1'b1, 1'b0);
    check(int'(rx_count) == 0, "rx_count_parity_err", int'(rx_count), 0);

    // Bad stop bit
    ev_q.push_back(EV_FRM);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    check(int'(rx_count) == 0, "rx_count_frame_err", int'(rx_count), 0);

    // Short low glitch
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(30);
    check(int'(rx_count) == 0, "rx_count_glitch", int'(rx_count), 0);
    $display("[TB] glitch done");

    // Overrun: fifth byte dropped
    rx_q.push_back(8'h01);
    send_rx(8'h01, 1'b1, 1'b1, 1'b0);
    rx_q.push_back(8'h02);
    send_rx(8'h02, 1'b1, 1'b1, 1'b0);
    rx_q.push_back(8'h03);
    send_rx(8'h03, 1'b0, 1'b1, 1'b0);
    rx_q.push_back(8'h04);
    send_rx(8'h04, 1'b1, 1'b1, 1'b0);
    ev_q.push_back(EV_OVR);
    send_rx(8'h05, 1'b0, 1'b1, 1'b0);
    check(int'(rx_count) == 4, "rx_count_full", int'(rx_count), 4);

    // Pop coinciding with push into a full FIFO: no overrun, count unchanged
    rx_q.push_back(8'h06);
    send_rx(8'h06, 1'b0, 1'b1, 1'b1);
    check(int'(rx_count) == 4, "rx_count_full_pop_push", int'(rx_count), 4);

    rx_ready = 1'b1;
    n = 0;
    while (rx_valid && n < 20) begin
      tick(1);
      n++;
    end
    rx_ready = 1'b0;
    check(rx_valid == 1'b0, "rx_drain", int'(rx_valid), 0);
    check(int'(rx_count) == 0, "rx_count_drained", int'(rx_count), 0);

`ifdef UART_LOOPBACK_EN
    loopback = 1'b1;
    rx_ready = 1'b1;
    tick(2);
    bad = 0;
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'h5A);
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!tx_ready && n < 200) begin
        if (uart_tx !== 1'b1) bad++;
        tick(1);
        n++;
      end
      check(tx_ready == 1'b1, "lb_tx_ready_timeout", int'(tx_ready), 1);
      tx_data  = (b == 0) ? 8'h00 : (b == 1) ? 8'hFF : 8'h5A;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
    end
    for (int i = 0; i < FRAME_CYC + 20; i++) begin
      if (uart_tx !== 1'b1) bad++;
      tick(1);
    end
    check(bad == 0, "lb_uart_tx_held_high", bad, 0);
    rx_ready = 1'b0;
    loopback = 1'b0;
    $display("[TB] loopback done");
`endif

    tick(20);
    check(rx_q.size() == 0, "rx_q_leftover", rx_q.size(), 0);
    check(tx_q.size() == 0, "tx_q_leftover", tx_q.size(), 0);
    check(ev_q.size() == 0, "ev_q_leftover", ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_trx.md
Name: uart_trx

Overview:
Parametrised full-duplex UART transceiver. It replaces the pin-level uart stub next to the vga, ps2_keyboard and vmem blocks in top.
- TX: byte-wide valid/ready input, configurable frame format.
- RX: 2-flop synchronizer, mid-bit sampling, error detection, and a receive FIFO drained by valid/ready.

Parameters:
- CLK_DIV, 868, clk cycles per bit (legal values ≥4; 868 gives 115200 baud at 100 MHz).
- DATA_BITS, 8, data bits per frame (5..8), sent and received LSB first.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits sent per frame (1 or 2). RX checks only the first stop bit.
- FIFO_DEPTH, 16, RX FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous reset, active-low.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter idle; a byte is accepted on tx_valid&&tx_ready.
- uart_tx  out  1  serial output, idle high, registered.
- uart_rx  in  1  serial input, asynchronous.
- rx_data  out  DATA_BITS  FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop FIFO head on rx_valid&&rx_ready.
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- frame_err  out  1  one-cycle pulse: bad stop bit.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- rx_overrun  out  1  one-cycle pulse: byte dropped, FIFO full.

Behaviour:
- Reset (resetn=0 at a clk edge): uart_tx=1, tx_ready=1, rx_valid=0, rx_count=0, all error pulses 0. FIFO is emptied and both FSMs return to IDLE, including mid-frame. A partial TX frame is aborted with the line high on the next cycle.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each bit lasts exactly CLK_DIV cycles.
  - The cycle after acceptance, uart_tx=0 and tx_ready=0.
  - DATA shifts DATA_BITS bits, LSB first.
  - PARITY state exists only if PARITY≠0. Odd parity: data XOR parity bit = 1. Even parity: = 0.
  - STOP holds 1 for STOP_BITS*CLK_DIV cycles, then tx_ready=1. The next byte may be accepted that same cycle, so back-to-back frames have no idle gap.
  - tx_data is captured on acceptance; later changes have no effect.
- RX synchronizer: uart_rx passes through 2 flops; all RX logic uses the synchronized value.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: a synchronized 0 enters START.
  - START: after CLK_DIV/2 cycles, resample. If 1, it is a glitch: return to IDLE, no error. If 0, continue.
  - DATA, PARITY, STOP: sample every CLK_DIV cycles, at bit centres.
- RX STOP sample 0: frame_err pulses, byte discarded. The FSM goes to IDLE and waits for the line to go high before arming again.
- RX parity mismatch with a valid stop bit: parity_err pulses, byte discarded.
- RX good frame: byte pushed in the cycle after the stop sample. If the FIFO is full at push, the byte is dropped and rx_overrun pulses; stored data is unchanged.
- FIFO:
  - First-word-fall-through: rx_data is valid whenever rx_valid=1.
  - Push and pop in the same cycle: both happen. This also applies when full, and the push is then not an overrun. rx_count is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- TX and RX are fully independent; simultaneous activity is legal.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: an extra input port loopback (1 bit) is present. When loopback=1, the RX synchronizer input is the internal TX serial bit and uart_tx is held at 1. When loopback=0, behaviour matches the undefined case. Switching loopback mid-frame is allowed; any resulting garbage is reported through the normal error pulses.
- Undefined: the port is absent and RX always takes uart_rx.

Test Plan:
- Reset/idle (CLK_DIV=8, PARITY=0): hold resetn=0 for 3 cycles -> uart_tx=1, tx_ready=1, rx_valid=0, rx_count=0.
- TX frame: send 0xA5 -> uart_tx bits 0,1,0,1,0,0,1,0,1,1, each 8 cycles wide. tx_ready=0 for 80 cycles, then 1. A second byte queued on tx_valid gives no idle gap.
- RX with even parity (PARITY=2): drive frame 0x3C with parity bit 0 -> rx_valid=1, rx_data=0x3C. Same frame with parity bit 1 -> one parity_err pulse, rx_count stays 0.
- RX framing and glitch: 0x55 with stop bit 0 -> one frame_err pulse, nothing pushed. A 2-cycle low glitch on uart_rx -> no push, no error.
- FIFO overrun (FIFO_DEPTH=4): receive 5 bytes 0x01..0x05 with rx_ready=0 -> rx_count=4, one rx_overrun pulse on the 5th byte, pops yield 0x01..0x04. Then pop while a byte arrives with the FIFO full -> no overrun, rx_count stays 4.
- Loopback (UART_LOOPBACK_EN, loopback=1): transmit 0x00, 0xFF, 0x5A -> same three bytes appear in order at rx_data, uart_tx held 1 throughout.
